// File: rtl/sser_tx_scrambler_if.sv
// rtl/sser_tx_scrambler_if.sv - host bus bundle for the SSER transmit window
interface sser_tx_scrambler_if;
  logic       SSER;
  logic       BA13;
  logic       BA12;
  logic [3:0] BA;    // BA7..BA4
  logic       BR_W;
  logic [7:0] BD;
  logic [7:0] BDO;
  logic       BDOE;

  modport master (
    output SSER, BA13, BA12, BA, BR_W, BD,
    input  BDO, BDOE
  );

  modport slave (
    input  SSER, BA13, BA12, BA, BR_W, BD,
    output BDO, BDOE
  );
endinterface

// File: rtl/sser_tx_scrambler.sv
// rtl/sser_tx_scrambler.sv - bus-mapped SSER transmitter with self-synchronising scrambler
// Define SSER_TX_PARITY_EN to add the odd-parity bit (11-bit frames instead of 10).
module sser_tx_scrambler #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sser_tx_scrambler_if.slave bus,
  output logic               SDWR,
  output logic               BUSY
);

`ifdef SSER_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t     state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] hold_q;
  logic       hold;
  logic       ovr;
  logic [5:0] scr;
  logic       sdwr_q;
  logic       busy_q;
  logic [7:0] bdo_q;
  logic       bdoe_q;
`ifdef SSER_TX_PARITY_EN
  logic       par;
`endif

  logic sel, wr, rd, data_wr, seed_wr;
  logic div_last, frame_end, start_now, ovr_set, hold_load;
  logic scr_out, bit_step;

  always_comb begin
    sel       = ~bus.SSER & ~bus.BA13 & bus.BA12;
    wr        = sel & ~bus.BR_W;
    rd        = sel & bus.BR_W;
    data_wr   = wr && (bus.BA == 4'h0);
    seed_wr   = wr && (bus.BA == 4'h1);
    div_last  = (div_cnt == 8'(CLK_DIV - 1));
    frame_end = (state == ST_STOP) && div_last;
    // A write landing on the final STOP clock with nothing held starts the next frame directly
    start_now = data_wr && ((state == ST_IDLE) || (frame_end && !hold));
    ovr_set   = data_wr && !start_now && hold;
    hold_load = data_wr && !start_now && !hold;
    scr_out   = shift_q[0] ^ scr[0] ^ scr[3] ^ scr[5];
    bit_step  = div_last && ((state == ST_START) || ((state == ST_DATA) && (bit_cnt != 3'd7)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= 8'h00;
      bit_cnt <= 3'd0;
      shift_q <= 8'h00;
      hold_q  <= 8'h00;
      hold    <= 1'b0;
      ovr     <= 1'b0;
      scr     <= 6'h00;
      sdwr_q  <= 1'b1;
      busy_q  <= 1'b0;
      bdo_q   <= 8'h00;
      bdoe_q  <= 1'b0;
`ifdef SSER_TX_PARITY_EN
      par     <= 1'b1;
`endif
    end else begin
      bdoe_q <= rd;
      bdo_q  <= 8'h00;
      if (rd) begin
        case (bus.BA)
          4'h0:    bdo_q <= {ovr, hold, busy_q, 5'b00000};
          4'h1:    bdo_q <= {2'b00, scr};
          default: bdo_q <= 8'h00;
        endcase
      end

      // Clear-on-read first so a simultaneous overrun still sets OVR
      if (rd && (bus.BA == 4'h0)) ovr <= 1'b0;
      if (ovr_set) ovr <= 1'b1;

      if (hold_load) begin
        hold_q <= bus.BD;
        hold   <= 1'b1;
      end

      if (seed_wr && (state == ST_IDLE)) scr <= bus.BD[5:0];

      div_cnt <= div_last ? 8'h00 : div_cnt + 8'h01;

      case (state)
        ST_IDLE: begin
          div_cnt <= 8'h00;
          if (start_now) begin
            shift_q <= bus.BD;
            state   <= ST_START;
            sdwr_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          bit_cnt <= 3'd0;
          if (div_last) state <= ST_DATA;
        end
        ST_DATA: begin
          if (div_last && (bit_cnt == 3'd7)) begin
`ifdef SSER_TX_PARITY_EN
            state  <= ST_PARITY;
            sdwr_q <= par;
`else
            state  <= ST_STOP;
            sdwr_q <= 1'b1;
`endif
          end
        end
`ifdef SSER_TX_PARITY_EN
        ST_PARITY: begin
          if (div_last) begin
            state  <= ST_STOP;
            sdwr_q <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (div_last) begin
            if (hold) begin
              shift_q <= hold_q;
              hold    <= 1'b0;
              state   <= ST_START;
              sdwr_q  <= 1'b0;
            end else if (start_now) begin
              shift_q <= bus.BD;
              state   <= ST_START;
              sdwr_q  <= 1'b0;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Scramble on the edge that opens each data bit so SDWR holds it for the full bit
      if (bit_step) begin
        sdwr_q  <= scr_out;
        scr     <= {scr[4:0], scr_out};
        shift_q <= {1'b0, shift_q[7:1]};
        if (state == ST_DATA) bit_cnt <= bit_cnt + 3'd1;
`ifdef SSER_TX_PARITY_EN
        par <= ((state == ST_START) ? 1'b1 : par) ^ scr_out;
`endif
      end
    end
  end

  assign SDWR     = sdwr_q;
  assign BUSY     = busy_q;
  assign bus.BDO  = bdo_q;
  assign bus.BDOE = bdoe_q;

endmodule

// File: tb/tb_sser_tx_scrambler.sv
// tb/tb_sser_tx_scrambler.sv - scoreboard bench for sser_tx_scrambler
module tb_sser_tx_scrambler;
  localparam int CLK_DIV = 4;
`ifdef SSER_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SDWR, BUSY;

  sser_tx_scrambler_if bus_if ();

  sser_tx_scrambler #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .SDWR  (SDWR),
    .BUSY  (BUSY)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic       exp_q[$];
  logic [5:0] model_s = 6'h00;
  int         busy_cnt = 0;

  // Serial scoreboard: one expected SDWR level per busy clock
  always @(negedge clk) begin
    logic e;
    if (rst_n && BUSY) begin
      busy_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL serial_extra: SDWR=%b while BUSY, no bit expected", SDWR);
      end else begin
        e = exp_q.pop_front();
        if (SDWR !== e) begin
          tests_failed++;
          $display("FAIL serial_bit: SDWR=%b expected %b at %0t", SDWR, e, $time);
        end
      end
    end else if (rst_n && SDWR !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL idle_line: SDWR=%b expected 1 while not BUSY", SDWR);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_bit(input logic b);
    for (int k = 0; k < CLK_DIV; k++) exp_q.push_back(b);
  endtask

  task automatic push_frame(input logic [7:0] d);
    logic par, o;
    par = 1'b1;
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      o = d[i] ^ model_s[0] ^ model_s[3] ^ model_s[5];
      model_s = {model_s[4:0], o};
      par = par ^ o;
      push_bit(o);
    end
`ifdef SSER_TX_PARITY_EN
    push_bit(par);
`endif
    push_bit(1'b1);
  endtask

  task automatic bus_idle();
    bus_if.SSER = 1'b1;
    bus_if.BA13 = 1'b0;
    bus_if.BA12 = 1'b0;
    bus_if.BA   = 4'h0;
    bus_if.BR_W = 1'b1;
    bus_if.BD   = 8'h00;
  endtask

  // Bus tasks are entered just after a rising edge; the access is captured on the next one
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus_if.SSER = 1'b0;
    bus_if.BA13 = 1'b0;
    bus_if.BA12 = 1'b1;
    bus_if.BA   = a;
    bus_if.BR_W = 1'b0;
    bus_if.BD   = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d, output logic oe);
    bus_if.SSER = 1'b0;
    bus_if.BA13 = 1'b0;
    bus_if.BA12 = 1'b1;
    bus_if.BA   = a;
    bus_if.BR_W = 1'b1;
    @(posedge clk); #1;
    d  = bus_if.BDO;
    oe = bus_if.BDOE;
    bus_idle();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_timeout: BUSY=%b expected 0 within 5000 clocks", name, BUSY);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_leftover: %0d expected bits unsent, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic oe;
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tests_run++;
    if (SDWR !== 1'b1 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_line: SDWR=%b BUSY=%b expected 1 0", SDWR, BUSY);
    end
    tests_run++;
    if (bus_if.BDO !== 8'h00 || bus_if.BDOE !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_bus: BDO=%h BDOE=%b expected 00 0", bus_if.BDO, bus_if.BDOE);
    end
    bus_read(4'h0, d, oe);
    tests_run++;
    if (d !== 8'h00 || oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_status: BDO=%h BDOE=%b expected 00 1", d, oe);
    end
    bus_read(4'h1, d, oe);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_seed: BDO=%h expected 00", d);
    end
  endtask

  task automatic test_zero_frame();
    logic [7:0] d;
    logic oe;
    bus_write(4'h1, 8'h00);
    model_s = 6'h00;
    busy_cnt = 0;
    push_frame(8'h00);
    bus_write(4'h0, 8'h00);
    wait_idle("zero_frame");
    tests_run++;
    if (busy_cnt != FRAME_CLKS) begin
      tests_failed++;
      $display("FAIL zero_frame_len: %0d busy clocks expected %0d", busy_cnt, FRAME_CLKS);
    end
    bus_read(4'h1, d, oe);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL zero_frame_seed: BDO=%h expected 00", d);
    end
  endtask

  task automatic test_seed_scramble();
    logic [7:0] d;
    logic oe;
    bus_write(4'h1, 8'h01);
    model_s = 6'h01;
    push_frame(8'h00);
    bus_write(4'h0, 8'h00);
    wait_idle("seed_scramble");
    bus_read(4'h1, d, oe);
    tests_run++;
    if (d !== 8'h2E || oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL seed_scramble_state: BDO=%h BDOE=%b expected 2e 1", d, oe);
    end
  endtask

  task automatic test_back_to_back();
    busy_cnt = 0;
    push_frame(8'hA5);
    bus_write(4'h0, 8'hA5);
    push_frame(8'h3C);
    bus_write(4'h0, 8'h3C);
    wait_idle("back_to_back");
    tests_run++;
    if (busy_cnt != 2 * FRAME_CLKS) begin
      tests_failed++;
      $display("FAIL back_to_back_len: %0d busy clocks expected %0d", busy_cnt, 2 * FRAME_CLKS);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic oe;
    push_frame(8'h11);
    bus_write(4'h0, 8'h11);
    push_frame(8'h22);
    bus_write(4'h0, 8'h22);
    bus_write(4'h0, 8'h33);
    bus_read(4'h0, d, oe);
    tests_run++;
    if (d !== 8'hE0 || oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_status: BDO=%h BDOE=%b expected e0 1", d, oe);
    end
    bus_read(4'h0, d, oe);
    tests_run++;
    if (d !== 8'h60) begin
      tests_failed++;
      $display("FAIL overrun_clear: BDO=%h expected 60", d);
    end
    wait_idle("overrun");
    bus_read(4'h0, d, oe);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL overrun_final_status: BDO=%h expected 00", d);
    end
  endtask

  task automatic test_seed_busy();
    logic [7:0] d;
    logic oe;
    push_frame(8'h5A);
    bus_write(4'h0, 8'h5A);
    bus_write(4'h1, 8'h15);
    wait_idle("seed_busy");
    bus_read(4'h1, d, oe);
    tests_run++;
    if (d !== {2'b00, model_s}) begin
      tests_failed++;
      $display("FAIL seed_busy_ignored: BDO=%h expected %h", d, {2'b00, model_s});
    end
  endtask

  task automatic test_write_at_busy_fall();
    busy_cnt = 0;
    push_frame(8'h81);
    bus_write(4'h0, 8'h81);
    repeat (FRAME_CLKS - 1) @(posedge clk);
    #1;
    push_frame(8'h7E);
    bus_write(4'h0, 8'h7E);
    wait_idle("busy_fall");
    tests_run++;
    if (busy_cnt != 2 * FRAME_CLKS) begin
      tests_failed++;
      $display("FAIL busy_fall_len: %0d busy clocks expected %0d", busy_cnt, 2 * FRAME_CLKS);
    end
  endtask

  task automatic test_other_regs();
    logic [7:0] d;
    logic oe;
    bus_read(4'h5, d, oe);
    tests_run++;
    if (d !== 8'h00 || oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL other_read: BDO=%h BDOE=%b expected 00 1", d, oe);
    end
    bus_if.SSER = 1'b0;
    bus_if.BA13 = 1'b0;
    bus_if.BA12 = 1'b0;
    bus_if.BR_W = 1'b1;
    @(posedge clk); #1;
    bus_idle();
    tests_run++;
    if (bus_if.BDOE !== 1'b0) begin
      tests_failed++;
      $display("FAIL unselected_read: BDOE=%b expected 0", bus_if.BDOE);
    end
    bus_write(4'h7, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL other_write: BUSY=%b expected 0", BUSY);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic oe;
    push_frame(8'hC3);
    bus_write(4'h0, 8'hC3);
    bus_write(4'h0, 8'h99);
    repeat (CLK_DIV * 3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    model_s = 6'h00;
    tests_run++;
    if (SDWR !== 1'b1 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_line: SDWR=%b BUSY=%b expected 1 0", SDWR, BUSY);
    end
    bus_read(4'h0, d, oe);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_status: BDO=%h expected 00", d);
    end
    bus_read(4'h1, d, oe);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_seed: BDO=%h expected 00", d);
    end
    repeat (2 * FRAME_CLKS) @(posedge clk);
    #1;
    tests_run++;
    if (BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold_discard: BUSY=%b expected 0", BUSY);
    end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_zero_frame();
    test_seed_scramble();
    test_back_to_back();
    test_overrun();
    test_seed_busy();
    test_write_at_busy_fall();
    test_other_regs();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
